// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite,
    StWdone
  } state_e;

  function automatic int unsigned idx_w(input int unsigned nlines);
    return $clog2(nlines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned nbits, input int unsigned nlines);
    return nbits - $clog2(nlines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage, one word per line, with combinational lookup and one write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned NLINES = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [idx_w(NLINES)-1:0]          lk_index,
  input  logic [tag_w(NBITS, NLINES)-1:0]   lk_tag,
  output logic                              hit,
  output logic [NBITS-1:0]                  rdata,
  input  logic                              we,
  input  logic [idx_w(NLINES)-1:0]          w_index,
  input  logic [tag_w(NBITS, NLINES)-1:0]   w_tag,
  input  logic [NBITS-1:0]                  w_data
);

  localparam int unsigned TW = tag_w(NBITS, NLINES);

  logic [NLINES-1:0] valid_q, valid_d;
  logic [TW-1:0]     tag_q  [NLINES];
  logic [NBITS-1:0]  data_q [NLINES];

  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[w_index] = 1'b1;
  end

  // Only valid bits need clearing; stale tag/data behind a clear valid are harmless.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    if (we) begin
      tag_q[w_index]  <= w_tag;
      data_q[w_index] <= w_data;
    end
  end

  assign hit   = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  assign rdata = data_q[lk_index];

endmodule

// File: rtl/dcache_responder.sv
// Write-through, no-write-allocate data cache responder: stalls the controller on misses/stores.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int unsigned NBITS  = 8,
  parameter int unsigned NLINES = 8,
  parameter int unsigned NCNT   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             busy,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [NCNT-1:0]  hits,
  output logic [NCNT-1:0]  misses
);

  localparam int unsigned IW = idx_w(NLINES);

  state_e           state_q, state_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic [NCNT-1:0]  hits_q, hits_d;
  logic [NCNT-1:0]  misses_q, misses_d;

  logic [NBITS-1:0] lk_addr;
  logic             hit;
  logic [NBITS-1:0] rdata;
  logic             idle, rd_hit, rd_miss, fill_we, wr_upd, arr_we;

  // In IDLE look up the live request; while busy look up the latched one.
  assign idle    = (state_q == StIdle);
  assign lk_addr = idle ? Address : addr_q;
  assign rd_hit  = idle && MemRead && !MemWrite && hit;
  assign rd_miss = idle && MemRead && !MemWrite && !hit;
  assign fill_we = (state_q == StFill) && mem_ack;
  assign wr_upd  = (state_q == StWrite) && mem_ack && hit;
  assign arr_we  = !reset && (fill_we || wr_upd);

  dcache_array #(
    .NBITS  (NBITS),
    .NLINES (NLINES)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .lk_index (lk_addr[IW-1:0]),
    .lk_tag   (lk_addr[NBITS-1:IW]),
    .hit      (hit),
    .rdata    (rdata),
    .we       (arr_we),
    .w_index  (addr_q[IW-1:0]),
    .w_tag    (addr_q[NBITS-1:IW]),
    .w_data   (fill_we ? mem_rdata : wdata_q)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hits_d   = (rd_hit && (hits_q != '1)) ? hits_q + 1'b1 : hits_q;
    misses_d = (rd_miss && (misses_q != '1)) ? misses_q + 1'b1 : misses_q;
    case (state_q)
      StIdle: begin
        if (MemWrite) begin
          state_d = StWrite;
          addr_d  = Address;
          wdata_d = WriteData;
        end else if (rd_miss) begin
          state_d = StFill;
          addr_d  = Address;
        end
      end
      StFill:  if (mem_ack) state_d = StIdle;
      StWrite: if (mem_ack) state_d = StWdone;
      StWdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    case (state_q)
      StIdle:          busy = MemWrite || rd_miss;
      StFill, StWrite: busy = 1'b1;
      default:         busy = 1'b0;
    endcase
    if (reset) busy = 1'b0;
  end

  assign mem_req   = !reset && ((state_q == StFill) || (state_q == StWrite));
  assign mem_we    = !reset && (state_q == StWrite);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ReadData  = (!reset && rd_hit) ? rdata : '0;
  assign hits      = hits_q;
  assign misses    = misses_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench with a backing-memory model, a cache-occupancy model and a read scoreboard.
module tb_dcache_responder;

  localparam int LAT = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       MemRead, MemWrite;
  logic [7:0] Address, WriteData, ReadData;
  logic       busy, mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack, ack_m, late_ack;
  logic [15:0] hits, misses;

  assign mem_ack = ack_m | late_ack;

  int checks = 0;
  int errors = 0;

  logic [7:0] bmem [256];
  logic [7:0] emem [256];
  logic       mvalid [8];
  logic [4:0] mtag [8];
  int         exp_hits, exp_misses;
  int         cnt;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;
  exp_t sb[$];

  dcache_responder #(
    .NBITS  (8),
    .NLINES (8),
    .NCNT   (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .hits      (hits),
    .misses    (misses)
  );

  always #5 clock = ~clock;

  // Backing memory: ack lands in the LAT-th cycle that mem_req is held.
  always @(posedge clock) begin
    if (reset) begin
      ack_m <= 1'b0;
      cnt   <= 0;
    end else if (mem_req && !ack_m) begin
      if (cnt == LAT - 2) begin
        ack_m     <= 1'b1;
        cnt       <= 0;
        mem_rdata <= bmem[mem_addr];
        if (mem_we) bmem[mem_addr] <= mem_wdata;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      ack_m <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  // Each task starts and ends 1 time unit after a rising edge.
  task automatic do_read(input logic [7:0] a);
    logic [2:0] idx;
    logic [4:0] tg;
    logic       mhit;
    int         nb;
    logic       done;
    exp_t       e;
    idx  = a[2:0];
    tg   = a[7:3];
    mhit = mvalid[idx] && (mtag[idx] == tg);
    sb.push_back('{data: emem[a], lat: (mhit ? 0 : LAT + 1)});
    if (!mhit) begin
      exp_misses++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    exp_hits++;
    MemRead = 1'b1;
    Address = a;
    nb      = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (busy) begin
        if (nb == 1) begin
          chk("fill_req", 32'(mem_req), 32'd1);
          chk("fill_we", 32'(mem_we), 32'd0);
          chk("fill_addr", 32'(mem_addr), 32'(a));
        end
        nb++;
      end else begin
        done = 1'b1;
      end
    end
    chk("read_done", 32'(done), 32'd1);
    e = sb.pop_front();
    chk("rdata", 32'(ReadData), 32'(e.data));
    chk("read_busy_cycles", 32'(nb), 32'(e.lat));
    chk("hit_no_req", 32'(mem_req), 32'd0);
    @(posedge clock);
    #1;
    MemRead = 1'b0;
    Address = '0;
    chk("hits", 32'(hits), 32'(exp_hits));
    chk("misses", 32'(misses), 32'(exp_misses));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic rd);
    int   nb;
    logic done;
    emem[a]   = d;
    MemWrite  = 1'b1;
    MemRead   = rd;
    Address   = a;
    WriteData = d;
    nb        = 0;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (busy) begin
        if (nb == 1) begin
          chk("wr_req", 32'(mem_req), 32'd1);
          chk("wr_we", 32'(mem_we), 32'd1);
          chk("wr_addr", 32'(mem_addr), 32'(a));
          chk("wr_wdata", 32'(mem_wdata), 32'(d));
        end
        nb++;
      end else begin
        done = 1'b1;
      end
    end
    chk("write_done", 32'(done), 32'd1);
    chk("write_busy_cycles", 32'(nb), 32'(LAT + 1));
    chk("wdone_rdata", 32'(ReadData), 32'd0);
    @(posedge clock);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    @(negedge clock);
    chk("post_write_idle", 32'(busy), 32'd0);
    chk("post_write_noreq", 32'(mem_req), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      bmem[i] = 8'(i) ^ 8'hA5;
    end
    bmem[8'h12] = 8'h5A;
    bmem[8'h40] = 8'h11;
    bmem[8'h1A] = 8'h9C;
    for (int i = 0; i < 256; i++) emem[i] = bmem[i];
    clear_model();
    mem_rdata = '0;
    late_ack  = 1'b0;
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", 32'(ReadData), 32'd0);
    chk("rst_hits", 32'(hits), 32'd0);
    chk("rst_misses", 32'(misses), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    do_read(8'h12);              // miss, fill with 0x5A
    do_read(8'h12);              // hit
    do_write(8'h12, 8'h77, 1'b0); // write-through hit
    do_read(8'h12);              // hit returns 0x77
    do_write(8'h40, 8'h33, 1'b1); // write miss with MemRead also high
    do_read(8'h40);              // no allocate -> miss
    do_read(8'h1A);              // evicts 0x12
    do_read(8'h12);              // misses again

    // Evict 0x12 then reset in the middle of the fill.
    MemRead = 1'b1;
    Address = 8'h1A;
    @(negedge clock);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    @(posedge clock);
    #1;
    reset   = 1'b1;
    MemRead = 1'b0;
    Address = '0;
    @(negedge clock);
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_model();
    late_ack = 1'b1;
    @(negedge clock);
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_req", 32'(mem_req), 32'd0);
    @(posedge clock);
    #1;
    late_ack = 1'b0;
    @(negedge clock);
    chk("after_late_ack_req", 32'(mem_req), 32'd0);
    chk("after_rst_hits", 32'(hits), 32'd0);
    chk("after_rst_misses", 32'(misses), 32'd0);
    @(posedge clock);
    #1;
    do_read(8'h12);              // cache cleared -> miss returns 0x77

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
